sram_controller: RTL
====================

# sram_controller

Responder side of the MEM-stage data-memory interface. It accepts the 32-bit word load/store that the MEM stage issues and executes it on an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states. While an access is in flight it holds `ready` low; the top level derives the pipeline freeze from this signal.

## Interface
Parameters:
- `WAIT_CYCLES`, 2, cycles each half-word phase is held on the SRAM pins; legal range 1..15.
- `BASE_ADDR`, 1024, byte address that maps to SRAM word 0.

Ports:
- `clk`, in, 1, the single clock; all state changes on its rising edge.
- `rst`, in, 1, reset; synchronous, active-high.
- `rd_en`, in, 1, MEM-stage load request; held until `ready`.
- `wr_en`, in, 1, MEM-stage store request; held until `ready`.
- `address`, in, 32, byte address; word-aligned, at or above `BASE_ADDR`.
- `write_data`, in, 32, store data.
- `read_data`, out, 32, load result; valid while `ready` is high in DONE after a read.
- `ready`, out, 1, high when no request is pending or in the completion cycle.
- `sram_addr`, out, 18, half-word address.
- `sram_dq_out`, out, 16, write data to the SRAM.
- `sram_dq_in`, in, 16, read data from the SRAM.
- `sram_dq_oe`, out, 1, drive enable for the DQ pads.
- `sram_we_n`, out, 1, write strobe, active-low.
- `sram_oe_n`, out, 1, output enable, active-low.

## Operation
- Word index = (`address` − `BASE_ADDR`) >> 2, truncated to 17 bits. The low half-word is at `sram_addr` = {index, 0}; the high half-word is at {index, 1}.
- States:
  - IDLE: if `wr_en` or `rd_en` is high, latch address, data and operation, then go to LOW.
  - LOW: hold for `WAIT_CYCLES` cycles, then go to HIGH.
  - HIGH: hold for `WAIT_CYCLES` cycles, then go to DONE.
  - DONE: one cycle, then return to IDLE unconditionally.
- If `wr_en` and `rd_en` are both high, the write wins.
- Write phases: `sram_dq_oe`=1 and `sram_we_n`=0 for the whole phase. `sram_dq_out` = `write_data[15:0]` in LOW and `[31:16]` in HIGH.
- Read phases: `sram_oe_n`=0. `sram_dq_in` is sampled on the last cycle of LOW into `read_data[15:0]` and on the last cycle of HIGH into `read_data[31:16]`.
- `ready` = (state==DONE) | (state==IDLE & ~(`rd_en`|`wr_en`)). This is combinational from state and requests.
- The request is still high during DONE. It is not re-accepted, because DONE always returns to IDLE.
- A back-to-back request is accepted in the IDLE cycle that follows DONE.
- The wait counter is 4 bits, loads `WAIT_CYCLES`−1 on each phase entry and decrements to 0.

## Timing
- Reset values:
  - state IDLE, counter 0, `read_data` 0.
  - `sram_we_n` 1, `sram_oe_n` 1, `sram_dq_oe` 0.
  - `sram_addr` 0, `sram_dq_out` 0.
  - `ready` follows its equation, so it is 1 with no request.
- Request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..W.
  - HIGH occupies cycles W+1..2W.
  - DONE (`ready`=1) is at cycle 2W+1.
  - Freeze lasts 2W+1 cycles; with W=2 that is 5.
- SRAM pins and `read_data` are registered. Between accesses they are held at the inactive levels.
- Reset during any state:
  - Next edge: IDLE, with strobes deasserted and `read_data` cleared.
  - A write in progress may leave only the low half written. This is accepted, not recovered.
- `read_data` keeps its last load value until the next read or reset. A write does not disturb it.

## Structure
- Shared package `sram_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - the `BASE_ADDR` default;
  - the SRAM width constants (16 data bits, 18 address bits).
- Single RTL module with no RTL sub-module.
- The bench uses a behavioural `sram_model` (256K×16 array) driven by `sram_we_n`, `sram_oe_n` and `sram_dq_oe`.

## Test plan
- Write 0xDEADBEEF to address 1024 with W=2 → half-word 0=0xBEEF, half-word 1=0xDEAD; `ready` low cycles 0..4, high at cycle 5.
- Read address 1024 after that write → `read_data`=0xDEADBEEF at cycle 5; `sram_oe_n` low cycles 1..4; `sram_we_n` never low.
- Back-to-back: write 0x12345678 to 1028, then read 1028 on the cycle after DONE → read returns 0x12345678; total 12 cycles from the first request.
- `rd_en`=`wr_en`=1, address 1032, data 0x0000FFFF → a write is performed; `read_data` unchanged.
- `rst` asserted in HIGH of a write → next cycle IDLE, strobes inactive, `read_data`=0, `ready`=1 with requests low.
- W=1 and W=15 variants of the first scenario → `ready` at cycle 3 and cycle 31 respectively.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the SRAM data-memory controller
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_ADDR_W = 18;

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word load/store executed as two half-word SRAM accesses
module sram_controller
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    sram_state_t            state;
    logic [3:0]             wait_cnt;
    logic                   op_write;
    logic [16:0]            word_idx;
    logic [SRAM_DATA_W-1:0] wdata_hi;
    logic [16:0]            req_idx;

    assign req_idx = 17'((address - BASE_ADDR) >> 2);

    assign ready = (state == DONE) || ((state == IDLE) && !(rd_en || wr_en));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            read_data   <= 32'd0;
            op_write    <= 1'b0;
            word_idx    <= 17'd0;
            wdata_hi    <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    // Pins are set up on the accepting edge so LOW starts the cycle after the request.
                    if (wr_en || rd_en) begin
                        op_write    <= wr_en;
                        word_idx    <= req_idx;
                        wdata_hi    <= write_data[31:16];
                        wait_cnt    <= WAIT_LOAD;
                        state       <= LOW;
                        sram_addr   <= {req_idx, 1'b0};
                        sram_dq_out <= wr_en ? write_data[15:0] : '0;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= !wr_en;
                        sram_oe_n   <= wr_en;
                    end
                end
                LOW: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= HIGH;
                        wait_cnt  <= WAIT_LOAD;
                        sram_addr <= {word_idx, 1'b1};
                        if (op_write) sram_dq_out <= wdata_hi;
                        else          read_data[15:0] <= sram_dq_in;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HIGH: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= DONE;
                        sram_addr   <= '0;
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        if (!op_write) read_data[31:16] <= sram_dq_in;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
